// File: rtl/rr_arb8.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb8
// Brief    : 8-requester round-robin arbiter with a mandatory one-cycle gap
//            between owners. It drives a registered grant index and a one-hot
//            grant vector for the shared select/decoder datapath.
//            Optional hold-time limit: define RR_ARB_HOLD_LIMIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb8 #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic       gnt_valid,
    output logic [2:0] gnt_idx,
    output logic [7:0] gnt_onehot,
    output logic       timeout
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_GRANT = 2'd1;
    localparam logic [1:0] c_GAP   = 2'd2;

    logic [1:0] r_state;
    logic [2:0] r_ptr;
    logic [2:0] r_gnt_idx;
    logic       r_gnt_valid;
    logic [7:0] r_gnt_onehot;

    logic [1:0] w_state_nxt;
    logic [2:0] w_winner;
    logic       w_found;
    logic       w_any;
    logic       w_release;
    logic       w_revoke;
    logic       w_limit_hit;
    logic       w_valid_nxt;
    logic [2:0] w_idx_nxt;
    logic [2:0] w_ptr_nxt;
    logic [7:0] w_onehot_nxt;

    assign w_any = |req;

    // Rotating-priority scan: first requester at or after r_ptr, wrapping 7->0.
    always_comb begin
        w_winner = r_ptr;
        w_found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && req[r_ptr + 3'(i)]) begin
                w_winner = r_ptr + 3'(i);
                w_found  = 1'b1;
            end
        end
    end

`ifdef RR_ARB_HOLD_LIMIT_EN
    localparam logic [7:0] c_HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] r_hold_cnt;
    logic       r_timeout;

    // Count consecutive GRANT cycles of the current owner, saturating at 255.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold_cnt <= 8'd0;
        end else if (r_state != c_GRANT) begin
            r_hold_cnt <= 8'd0;
        end else if (r_hold_cnt != 8'hFF) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
        end
    end

    assign w_limit_hit = (r_hold_cnt == c_HOLD_LAST);

    // One-cycle pulse in the GAP that follows a forced revocation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_revoke;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_limit_hit = 1'b0;
    assign timeout     = 1'b0;
`endif

    // State and registered outputs; reset drops any grant immediately.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_ptr        <= 3'd0;
            r_gnt_idx    <= 3'd0;
            r_gnt_valid  <= 1'b0;
            r_gnt_onehot <= 8'h00;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_gnt_idx    <= w_idx_nxt;
            r_gnt_valid  <= w_valid_nxt;
            r_gnt_onehot <= w_onehot_nxt;
        end
    end

    // Next state: owner keeps the grant until it drops req or hits the limit.
    always_comb begin
        w_state_nxt = r_state;
        w_release   = 1'b0;
        w_revoke    = 1'b0;
        case (r_state)
            c_IDLE, c_GAP: begin
                w_state_nxt = w_any ? c_GRANT : c_IDLE;
            end
            c_GRANT: begin
                if (!req[r_gnt_idx]) begin
                    w_state_nxt = c_GAP;
                    w_release   = 1'b1;
                end else if (w_limit_hit) begin
                    w_state_nxt = c_GAP;
                    w_revoke    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and the priority pointer.
    always_comb begin
        w_valid_nxt  = (w_state_nxt == c_GRANT);
        w_idx_nxt    = ((r_state != c_GRANT) && w_any) ? w_winner : r_gnt_idx;
        w_ptr_nxt    = (w_release || w_revoke) ? (r_gnt_idx + 3'd1) : r_ptr;
        w_onehot_nxt = w_valid_nxt ? (8'h01 << w_idx_nxt) : 8'h00;
    end

    assign gnt_valid  = r_gnt_valid;
    assign gnt_idx    = r_gnt_idx;
    assign gnt_onehot = r_gnt_onehot;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb8.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb8
// Brief    : Directed self-checking bench for rr_arb8 (reset, rotation, wrap,
//            single requester, mid-grant reset, hold limit / no hold limit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arb8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic [7:0] gnt_onehot;
    logic       timeout;

    int vectors    = 0;
    int miscompares = 0;

    rr_arb8 #(
        .N        (8),
        .MAX_HOLD (16)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic ev, input logic [2:0] ei,
                         input logic et);
        logic [7:0] eo;
        eo = ev ? (8'h01 << ei) : 8'h00;
        vectors += 4;
        assert (gnt_valid === ev) else begin
            miscompares++;
            $error("FAIL %s gnt_valid observed=%0b expected=%0b", tag, gnt_valid, ev);
        end
        assert (gnt_idx === ei) else begin
            miscompares++;
            $error("FAIL %s gnt_idx observed=%0d expected=%0d", tag, gnt_idx, ei);
        end
        assert (gnt_onehot === eo) else begin
            miscompares++;
            $error("FAIL %s gnt_onehot observed=%02h expected=%02h", tag, gnt_onehot, eo);
        end
        assert (timeout === et) else begin
            miscompares++;
            $error("FAIL %s timeout observed=%0b expected=%0b", tag, timeout, et);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'hFF;

        // Reset held two cycles with every requester active.
        tick(); check("reset0", 1'b0, 3'd0, 1'b0);
        tick(); check("reset1", 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
        tick(); check("first_grant", 1'b1, 3'd0, 1'b0);

        // Rotation: each owner holds 3 cycles, drops req one cycle, re-asserts.
        for (int k = 0; k < 8; k++) begin
            tick(); check("rot_hold", 1'b1, 3'(k), 1'b0);
            tick(); check("rot_hold", 1'b1, 3'(k), 1'b0);
            req = 8'hFF & ~(8'h01 << k);
            tick(); check("rot_gap", 1'b0, 3'(k), 1'b0);
            req = 8'hFF;
            tick(); check("rot_next", 1'b1, 3'(k + 1), 1'b0);
        end

        // Wrap: get owner 5, release it so ptr=6, then request {5,0}.
        req = 8'h20;
        tick(); check("wrap_gap0", 1'b0, 3'd0, 1'b0);
        tick(); check("wrap_own5", 1'b1, 3'd5, 1'b0);
        req = 8'h01;
        tick(); check("wrap_gap5", 1'b0, 3'd5, 1'b0);
        req = 8'h21;
        tick(); check("wrap_win0", 1'b1, 3'd0, 1'b0);
        req = 8'h20;
        tick(); check("wrap_gap0b", 1'b0, 3'd0, 1'b0);
        tick(); check("wrap_win5", 1'b1, 3'd5, 1'b0);

        // Single requester 3: 4 cycles on, 1 off, re-granted through rotation.
        req = 8'h08;
        tick(); check("single_gap5", 1'b0, 3'd5, 1'b0);
        tick(); check("single_g3", 1'b1, 3'd3, 1'b0);
        for (int r = 0; r < 3; r++) begin
            tick(); check("single_hold", 1'b1, 3'd3, 1'b0);
            tick(); check("single_hold", 1'b1, 3'd3, 1'b0);
            tick(); check("single_hold", 1'b1, 3'd3, 1'b0);
            req = 8'h00;
            tick(); check("single_gap", 1'b0, 3'd3, 1'b0);
            req = 8'h08;
            tick(); check("single_regrant", 1'b1, 3'd3, 1'b0);
        end

        // Mid-grant reset with owner 4.
        req = 8'h10;
        tick(); check("mrst_gap3", 1'b0, 3'd3, 1'b0);
        tick(); check("mrst_own4", 1'b1, 3'd4, 1'b0);
        rst_n = 1'b0;
        tick(); check("mrst_drop", 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
        tick(); check("mrst_regrant", 1'b1, 3'd4, 1'b0);

        // Hold behaviour with req[1:0] held constant; ptr=5 so 0 wins first.
        req = 8'h03;
        tick(); check("hold_gap4", 1'b0, 3'd4, 1'b0);
        tick(); check("hold_own0", 1'b1, 3'd0, 1'b0);
`ifdef RR_ARB_HOLD_LIMIT_EN
        for (int c = 0; c < 15; c++) begin
            tick(); check("lim_hold0", 1'b1, 3'd0, 1'b0);
        end
        tick(); check("lim_timeout0", 1'b0, 3'd0, 1'b1);
        tick(); check("lim_own1", 1'b1, 3'd1, 1'b0);
        for (int c = 0; c < 15; c++) begin
            tick(); check("lim_hold1", 1'b1, 3'd1, 1'b0);
        end
        tick(); check("lim_timeout1", 1'b0, 3'd1, 1'b1);
        tick(); check("lim_own0b", 1'b1, 3'd0, 1'b0);
`else
        for (int c = 0; c < 100; c++) begin
            tick(); check("nolim_hold0", 1'b1, 3'd0, 1'b0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_arb8.md
Name: rr_arb8

Overview:
- 8-requester round-robin arbiter. Shares one decoded resource (3-bit select into a 3-to-8 one-hot decoder) among requesters.
- Produces a registered grant index and the matching one-hot grant vector (decoder output gated by grant valid).
- Guarantees fairness: rotating priority, mandatory dead cycle between owners, optional hold-time limit.
- Sits between requesting masters and the shared select/decoder datapath.

Parameters:
- N, 8, number of requesters; fixed at 8, and the index width is 3.
- MAX_HOLD, 16, maximum consecutive grant cycles per owner (used only with the optional feature); legal range 2..255.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on the clk rising edge.
- req  input  8  request vector; req[k] high while requester k wants or holds the resource.
- gnt_valid  output  1  a grant is active this cycle.
- gnt_idx  output  3  index of the current owner; holds the last owner when gnt_valid=0.
- gnt_onehot  output  8  one-hot decode of gnt_idx, gated by gnt_valid; all zeros when gnt_valid=0.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked (optional feature only; else tied 0).

Behaviour:
- Outputs: all registered; no combinational path from req to any output.
- Reset (rst_n=0 at an edge):
  - state=IDLE, ptr=0, gnt_idx=0, gnt_valid=0, gnt_onehot=8'h00, hold_cnt=0, timeout=0.
  - Reset mid-grant drops the grant on the next edge, with no GAP cycle.
- States: IDLE, GRANT, GAP.
- Winner selection:
  - Winner = first k with req[k]=1, scanning ptr, ptr+1, ... ptr+7, all mod 8 (wrap 7->0).
  - ptr = highest-priority index for the next arbitration.
- IDLE:
  - req==0: stay in IDLE.
  - Otherwise: next edge GRANT, gnt_idx=winner, gnt_valid=1, hold_cnt=0.
  - Latency from req sampled to gnt_valid: 1 cycle.
- GRANT:
  - Owner keeps the grant while req[gnt_idx]=1. Other requests are ignored, with no preemption.
  - hold_cnt increments each GRANT cycle and saturates at 255.
  - req[gnt_idx]=0 sampled: next edge GAP, gnt_valid=0, ptr=gnt_idx+1 mod 8.
- GAP:
  - Exactly one cycle with gnt_valid=0 and gnt_onehot=0. This is the bus turnaround.
  - Arbitration is evaluated in GAP exactly as in IDLE. Any req goes to GRANT on the next edge; else IDLE.
  - Release-to-next-grant latency: 2 cycles.
- Re-grant to the same requester:
  - Allowed only through the rotation, i.e. when no other req is set.
  - Example: owner 3 releases and re-requests in GAP with no others → 3 wins again.
- Simultaneous requests: resolved purely by rotating priority from ptr. Lowest index is not favoured except when ptr=0.
- req glitch: a requester dropping req for one cycle loses its grant; it does not resume.
- gnt_onehot == (gnt_valid ? 1<<gnt_idx : 0) in every cycle. This is a checkable invariant.

Optional Feature:
- Macro: RR_ARB_HOLD_LIMIT_EN.
- Defined:
  - In GRANT, when hold_cnt == MAX_HOLD-1 and req[gnt_idx] is still 1, the next edge goes to GAP with ptr=gnt_idx+1 and timeout=1 for that one cycle.
  - The owner must re-arbitrate; it may win again only if no other req is set.
  - A grant lasts at most MAX_HOLD cycles.
  - If the owner releases on the same cycle the limit is reached, this is a normal release with timeout=0.
- Undefined: no hold limit; hold_cnt may be removed; timeout is constant 0.

Test Plan:
- Reset: hold rst_n=0 2 cycles with req=8'hFF → gnt_valid=0, gnt_onehot=8'h00, gnt_idx=0. Release rst_n → first grant to idx 0 one cycle later, gnt_onehot=8'h01.
- Rotation: req=8'hFF held; each owner drops req for 1 cycle after 3 grant cycles, then re-asserts → grant order 0,1,2,...,7,0. Every grant separated by exactly one gnt_valid=0 cycle.
- Wrap and sparse requests: ptr=6 (after owner 5 released), req=8'b0010_0001 → winner idx 0 (5 is behind ptr), gnt_onehot=8'h01. Then idx 5.
- Single requester: only req[3] toggles: 4 cycles on, 1 cycle off, repeated → 3 re-granted each time, 2-cycle release-to-grant latency.
- Mid-grant reset: owner 4 granted, rst_n=0 for 1 cycle → next cycle gnt_valid=0, ptr=0. With req=8'h10 still set after reset → grant to 4 after 1 cycle.
- Hold limit (RR_ARB_HOLD_LIMIT_EN, MAX_HOLD=16): req=8'h03 held constant → idx 0 granted 16 cycles, timeout=1 in the GAP cycle, then idx 1 granted 16 cycles, alternating. Without the macro: idx 0 holds indefinitely (check 100 cycles), timeout=0.
